// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: 16 x {header marker, byte} with packet length tracking.
// Optional sticky overflow/underflow flags are enabled by defining ROUTER_FIFO_ERR_FLAG_EN.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_reset,
    input  logic             wr_en,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_active,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH:0]  mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [6:0]      pkt_cnt;
    logic            do_wr;
    logic            do_rd;
    logic            flush;
    logic [WIDTH:0]  rd_entry;

    assign flush    = rst || soft_reset;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_en && !empty;
    assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!flush && do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= rd_entry[WIDTH-1:0];
                // Header byte carries payload length in [7:2]; +1 accounts for the parity byte.
                if (rd_entry[WIDTH]) begin
                    pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - 7'd1;
                end
            end
        end
    end

    assign pkt_active = (pkt_cnt != '0);

`ifdef ROUTER_FIFO_ERR_FLAG_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo; expectations are hand-computed constants.
module tb_router_fifo;

    logic       clk;
    logic       rst;
    logic       soft_reset;
    logic       wr_en;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_active;
    logic       overflow_err;
    logic       underflow_err;

`ifdef ROUTER_FIFO_ERR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    int n_checks;
    int n_fail;

    router_fifo #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_reset   (soft_reset),
        .wr_en        (wr_en),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .pkt_active   (pkt_active),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        lfd_state  = 1'b0;
        soft_reset = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic hdr);
        idle();
        wr_en     = 1'b1;
        lfd_state = hdr;
        data_in   = d;
        step();
        idle();
    endtask

    task automatic pop();
        idle();
        rd_en = 1'b1;
        step();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        data_in  = 8'h00;
        idle();

        // Reset and idle
        rst = 1'b1;
        step();
        idle();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_pkt", 32'(pkt_active), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("rst_unf", 32'(underflow_err), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h10 + i), 1'b0);
            if (i == 14) check("full_at_15", 32'(full), 32'd0);
        end
        check("full_at_16", 32'(full), 32'd1);
        check("empty_at_16", 32'(empty), 32'd0);
        push(8'hAA, 1'b0);
        check("full_after_drop", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow_err), 32'(ERR_EN));
        for (int i = 0; i < 16; i++) begin
            pop();
            check($sformatf("drain_%0d", i), 32'(data_out), 32'(8'h10 + i));
            if (i == 0) check("full_after_1rd", 32'(full), 32'd0);
            check("no_pkt_unmarked", 32'(pkt_active), 32'd0);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Read when empty: data_out holds, pointers unchanged
        pop();
        check("uf_hold", 32'(data_out), 32'h1F);
        check("uf_empty", 32'(empty), 32'd1);
        check("uf_full", 32'(full), 32'd0);
        check("unf_flag", 32'(underflow_err), 32'(ERR_EN));
        push(8'h55, 1'b0);
        check("uf_not_empty", 32'(empty), 32'd0);
        pop();
        check("uf_ptr_ok", 32'(data_out), 32'h55);
        check("uf_empty2", 32'(empty), 32'd1);

        // Packet tracking: header 0x0C -> length 3, counter 4
        push(8'h0C, 1'b1);
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b0);
        push(8'h0E, 1'b0);
        pop();
        check("hdr_data", 32'(data_out), 32'h0C);
        check("hdr_active", 32'(pkt_active), 32'd1);
        for (int i = 0; i < 4; i++) begin
            pop();
            check($sformatf("pkt_active_%0d", i), 32'(pkt_active), (i < 3) ? 32'd1 : 32'd0);
        end
        check("pkt_parity", 32'(data_out), 32'h0E);
        check("pkt_empty", 32'(empty), 32'd1);

        // Wrap and concurrency: 8 stored, then 40 simultaneous read/write cycles
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            idle();
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            data_in = 8'(8'h28 + i);
            step();
            check($sformatf("wrap_%0d", i), 32'(data_out), 32'(8'h20 + i));
        end
        idle();
        check("wrap_not_empty", 32'(empty), 32'd0);
        check("wrap_not_full", 32'(full), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pop();
            check($sformatf("wrap_tail_%0d", i), 32'(data_out), 32'(8'h48 + i));
        end
        check("wrap_occ8_empty", 32'(empty), 32'd1);

        // Soft reset mid-packet: header 0x08 -> counter 3, with 5 more entries stored
        push(8'h08, 1'b1);
        for (int i = 0; i < 5; i++) push(8'(8'hA1 + i), 1'b0);
        pop();
        check("sr_pre_active", 32'(pkt_active), 32'd1);
        check("sr_pre_data", 32'(data_out), 32'h08);
        check("sr_pre_ovf", 32'(overflow_err), 32'(ERR_EN));
        idle();
        soft_reset = 1'b1;
        wr_en      = 1'b1;
        rd_en      = 1'b1;
        data_in    = 8'hEE;
        step();
        idle();
        check("sr_empty", 32'(empty), 32'd1);
        check("sr_full", 32'(full), 32'd0);
        check("sr_active", 32'(pkt_active), 32'd0);
        check("sr_data", 32'(data_out), 32'h00);
        check("sr_ovf", 32'(overflow_err), 32'd0);
        check("sr_unf", 32'(underflow_err), 32'd0);
        push(8'h77, 1'b0);
        check("sr_wr_not_empty", 32'(empty), 32'd0);
        pop();
        check("sr_new_byte", 32'(data_out), 32'h77);
        check("sr_final_empty", 32'(empty), 32'd1);
        check("sr_final_active", 32'(pkt_active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-port output FIFO of the 1x3 packet router. It sits directly downstream of the synchronizer.
- Three instances are used, one per destination port. Instance N takes `wr_en[N]` and `soft_reset_N` from the synchronizer and returns `full_N` and `empty_N` to it.
- Each entry stores one packet byte plus a header marker. The read side tracks how many bytes of the current packet remain, so the destination knows when the packet ends.

Parameters:
- WIDTH, 8: data byte width.
- ADDR_W, 4: address width; depth = 2**ADDR_W = 16 entries.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- soft_reset  input  1  synchronous flush from the synchronizer timeout; active-high.
- wr_en  input  1  write strobe (synchronizer wr_en bit for this port).
- lfd_state  input  1  high when data_in is the packet header byte.
- data_in  input  WIDTH  byte to store.
- rd_en  input  1  read strobe from the destination.
- data_out  output  WIDTH  registered read data.
- full  output  1  no free entry.
- empty  output  1  no stored entry.
- pkt_active  output  1  high while bytes of the current packet remain to be read.
- overflow_err  output  1  sticky error flag (see Optional Feature).
- underflow_err  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Storage: 2**ADDR_W entries, each WIDTH+1 bits = {lfd_state, data_in}. Memory contents are not cleared by any reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = MSBs differ and the lower ADDR_W bits are equal.
- full and empty are combinational from the registered pointers.
- Write: if wr_en && !full, store the entry at wr_ptr and increment wr_ptr (natural wrap). wr_en while full is dropped; no state change.
- Read: if rd_en && !empty, data_out <= stored byte at rd_ptr (1-cycle latency) and increment rd_ptr. rd_en while empty leaves data_out unchanged.
- Simultaneous rd_en && wr_en:
  - Both are evaluated against the pre-edge full/empty.
  - When full, the read proceeds and the write is dropped.
  - When empty, the write proceeds and the read is ignored.
  - Otherwise both occur and occupancy is unchanged.
- Packet counter pkt_cnt, 7 bits:
  - Reading an entry whose marker bit is 1 loads pkt_cnt <= data[7:2] + 1 (payload length + parity byte).
  - Reading an unmarked entry while pkt_cnt != 0 decrements pkt_cnt.
  - Reading an unmarked entry while pkt_cnt == 0 leaves it at 0.
  - pkt_active = (pkt_cnt != 0), registered.
- Reset (rst = 1): next edge sets wr_ptr = 0, rd_ptr = 0, pkt_cnt = 0, data_out = 0, overflow_err = 0, underflow_err = 0. Hence full = 0, empty = 1, pkt_active = 0. rst overrides all other inputs.
- soft_reset = 1 (rst = 0): identical effect to rst on the next edge. Any write or read in the same cycle is discarded. Applies mid-packet; a packet partially read is abandoned.

Optional Feature:
- Macro: ROUTER_FIFO_ERR_FLAG_EN.
- With the macro defined:
  - overflow_err sets on wr_en && full.
  - underflow_err sets on rd_en && empty.
  - Both are sticky until rst or soft_reset clears them.
- Without the macro: both ports remain present, driven constant 0, and no flag logic is generated. The instantiation is identical either way.

Test Plan:
- Reset and idle: rst high 1 cycle -> empty = 1, full = 0, data_out = 8'h00, pkt_active = 0.
- Fill and overflow:
  - Write 16 bytes 8'h10..8'h1F -> full = 1 after the 16th.
  - 17th write of 8'hAA is dropped.
  - Read 16 bytes -> 8'h10..8'h1F in order, empty = 1.
  - overflow_err = 1 only with the macro, else 0.
- Packet tracking:
  - Write header 8'h0C (len 3) with lfd_state = 1, then 3 payload bytes and 1 parity byte.
  - Read the header -> pkt_active = 1 with pkt_cnt = 4.
  - pkt_active falls on the cycle after the 4th non-header read.
- Wrap and concurrency:
  - Keep 8 entries, then 40 cycles of simultaneous rd_en/wr_en with incrementing data.
  - Output stream stays in order through pointer wrap; occupancy stays 8.
- Read when empty: rd_en with empty = 1 -> data_out holds its previous value, pointers unchanged, underflow_err per macro.
- Soft reset mid-packet:
  - Assert soft_reset with 5 entries stored and pkt_active = 1.
  - Next cycle: empty = 1, pkt_active = 0, data_out = 0, error flags cleared.
  - A following write/read returns the new byte.
